// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared types for the GCD operand/result interface, used by both the engine
// and the requester:
//   GCD_WIDTH       : operand/result width carried by gcd_data
//   gcd_data        : operand pair {a, b} sent to the engine
//   gcd_status_e    : result status (ok / zero short-circuit / timeout)
//   gcd_req_state_e : requester FSM state, exported so benches can probe it
// -----------------------------------------------------------------------------
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef struct packed {
        logic [GCD_WIDTH-1:0] a;
        logic [GCD_WIDTH-1:0] b;
    } gcd_data;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_ZERO    = 2'b01,
        ST_TIMEOUT = 2'b10
    } gcd_status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } gcd_req_state_e;

    // The subtractive engine never terminates when either operand is zero,
    // so such pairs must be resolved before they reach it.
    function automatic logic has_zero(input gcd_data pair);
        return (pair.a == '0) || (pair.b == '0);
    endfunction

endpackage : gcd_pkg

// File: rtl/gcd_timeout_cnt.sv
// -----------------------------------------------------------------------------
// gcd_timeout_cnt
// Saturating cycle counter with synchronous clear and count enable. expired_o
// is decoded from the registered count, so it carries no input-to-output path.
//   clk_i     in   rising-edge clock
//   nreset_i  in   asynchronous, active-low reset
//   clear_i   in   return count to zero (wins over enable)
//   enable_i  in   count up by one, holding at LIMIT
//   expired_o out  count has reached LIMIT
// -----------------------------------------------------------------------------
module gcd_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CNT_W   = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LIMIT_V)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LIMIT_V);

endmodule : gcd_timeout_cnt

// File: rtl/gcd_requester.sv
// -----------------------------------------------------------------------------
// gcd_requester
// Initiator side of the GCD operand/result interface. Takes an operand pair
// from the command port, issues it to the engine over a valid/ready channel,
// waits (bounded by TIMEOUT) for the single-cycle response and returns the
// result with a status. Pairs containing zero are answered locally.
//   clk_i, nreset_i            clock, async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake, operands cmd_a_i, cmd_b_i
//   req_valid_o / req_ready_i  request handshake to engine, operands req_o
//   rsp_valid_i, rsp_gcd_i     engine result pulse (no backpressure)
//   res_valid_o / res_ready_i  result handshake: res_gcd_o, res_status_o,
//                              res_coprime_o
//   busy_o                     a transaction is in progress
// DATA_WIDTH must equal gcd_pkg::GCD_WIDTH because req_o is a gcd_data.
// Every output is a register or a decode of registered state.
// -----------------------------------------------------------------------------
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = GCD_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] cmd_a_i,
    input  logic [DATA_WIDTH-1:0] cmd_b_i,
    output logic                  req_valid_o,
    input  logic                  req_ready_i,
    output gcd_data               req_o,
    input  logic                  rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] rsp_gcd_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_gcd_o,
    output gcd_status_e           res_status_o,
    output logic                  res_coprime_o,
    output logic                  busy_o
);

    gcd_req_state_e        state_q, state_d;
    gcd_data               pair_q;
    gcd_data               cmd_pair;
    logic [DATA_WIDTH-1:0] res_gcd_q;
    gcd_status_e           res_status_q;
    logic                  cmd_zero;
    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_expired;

    assign cmd_pair = '{a: cmd_a_i, b: cmd_b_i};
    assign cmd_zero = has_zero(cmd_pair);

    // The count restarts on the request handshake, so the wait window is
    // measured from the first S_WAIT cycle rather than from command accept.
    assign timer_clear  = (state_q == S_ISSUE) && req_ready_i;
    assign timer_enable = (state_q == S_WAIT);

    gcd_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = cmd_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid_i || timer_expired) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand and result registers only load in the state that owns them, so
    // req_o is frozen through S_ISSUE and the result through S_RESP.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            pair_q       <= '0;
            res_gcd_q    <= '0;
            res_status_q <= ST_OK;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        pair_q <= cmd_pair;
                        if (cmd_zero) begin
                            // gcd(x, 0) = x, and the OR also covers (0, 0).
                            res_gcd_q    <= cmd_a_i | cmd_b_i;
                            res_status_q <= ST_ZERO;
                        end
                    end
                end
                S_WAIT: begin
                    // A response on the expiry cycle is still a valid answer.
                    if (rsp_valid_i) begin
                        res_gcd_q    <= rsp_gcd_i;
                        res_status_q <= ST_OK;
                    end else if (timer_expired) begin
                        res_gcd_q    <= '0;
                        res_status_q <= ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign req_valid_o   = (state_q == S_ISSUE);
    assign res_valid_o   = (state_q == S_RESP);
    assign busy_o        = (state_q != S_IDLE);
    assign req_o         = pair_q;
    assign res_gcd_o     = res_gcd_q;
    assign res_status_o  = res_status_q;
    assign res_coprime_o = (res_gcd_q == DATA_WIDTH'(1)) && (res_status_q == ST_OK);

endmodule : gcd_requester

// File: tb/tb_gcd_requester.sv
// -----------------------------------------------------------------------------
// tb_gcd_requester
// Self-checking bench for gcd_requester with TIMEOUT = 4. The bench plays the
// engine and the result consumer; expected results come from Euclid's
// algorithm and the rule "answered iff the response latency fits the window".
// -----------------------------------------------------------------------------
module tb_gcd_requester;
    import gcd_pkg::*;

    localparam int DW         = GCD_WIDTH;
    localparam int TB_TIMEOUT = 4;

    logic          clk_i = 1'b0;
    logic          nreset_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [DW-1:0] cmd_a_i;
    logic [DW-1:0] cmd_b_i;
    logic          req_valid_o;
    logic          req_ready_i;
    gcd_data       req_o;
    logic          rsp_valid_i;
    logic [DW-1:0] rsp_gcd_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [DW-1:0] res_gcd_o;
    gcd_status_e   res_status_o;
    logic          res_coprime_o;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_req   = 0;

    gcd_requester #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .nreset_i      (nreset_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_a_i       (cmd_a_i),
        .cmd_b_i       (cmd_b_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_o         (req_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_gcd_i     (rsp_gcd_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_gcd_o     (res_gcd_o),
        .res_status_o  (res_status_o),
        .res_coprime_o (res_coprime_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts accepted engine requests.
    always @(posedge clk_i) begin
        if (nreset_i && req_valid_o && req_ready_i) n_req <= n_req + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1);
        check({tag, "_req_valid"}, req_valid_o, 0);
        check({tag, "_res_valid"}, res_valid_o, 0);
        check({tag, "_coprime"}, res_coprime_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_req_o"}, req_o, 0);
        check({tag, "_res_gcd"}, res_gcd_o, 0);
        check({tag, "_status"}, int'(res_status_o), int'(ST_OK));
    endtask

    // One full transaction. req_wait: cycles req_ready_i is held low;
    // rsp_lat: S_WAIT cycle (0-based) in which the engine pulses rsp_valid_i;
    // res_wait: cycles res_ready_i is held low.
    task automatic run_txn(input int a, input int b, input int req_wait,
                           input int rsp_lat, input int res_wait);
        int  exp_gcd, exp_status, exp_cyc, req_before, cyc;
        bit  zero, done;
        zero = (a == 0) || (b == 0);
        if (zero) begin
            exp_gcd = a | b;
            exp_status = int'(ST_ZERO);
        end else if (rsp_lat <= TB_TIMEOUT) begin
            exp_gcd = ref_gcd(a, b);
            exp_status = int'(ST_OK);
        end else begin
            exp_gcd = 0;
            exp_status = int'(ST_TIMEOUT);
        end
        exp_cyc = (rsp_lat < TB_TIMEOUT) ? rsp_lat : TB_TIMEOUT;

        check("cmd_ready_idle", cmd_ready_o, 1);
        req_before = n_req;
        cmd_valid_i = 1'b1;
        cmd_a_i = DW'(a);
        cmd_b_i = DW'(b);
        tick();
        cmd_valid_i = 1'b0;
        cmd_a_i = DW'($urandom);
        cmd_b_i = DW'($urandom);

        if (!zero) begin
            check("req_valid", req_valid_o, 1);
            check("res_valid_early", res_valid_o, 0);
            check("cmd_ready_busy", cmd_ready_o, 0);
            for (int i = 0; i < req_wait; i++) begin
                tick();
                check("req_valid_hold", req_valid_o, 1);
            end
            check("req_a", req_o.a, a);
            check("req_b", req_o.b, b);
            req_ready_i = 1'b1;
            tick();
            req_ready_i = 1'b0;
            check("req_valid_drop", req_valid_o, 0);
            check("busy_wait", busy_o, 1);

            cyc = 0;
            done = 1'b0;
            repeat (TB_TIMEOUT + 4) begin
                if (!done) begin
                    rsp_valid_i = (cyc == rsp_lat);
                    rsp_gcd_i = DW'(ref_gcd(a, b));
                    tick();
                    rsp_valid_i = 1'b0;
                    if (res_valid_o) done = 1'b1;
                    else cyc++;
                end
            end
            check("wait_done", done, 1);
            check("wait_cycles", cyc, exp_cyc);
        end else begin
            check("req_valid_zero", req_valid_o, 0);
        end

        check("res_valid", res_valid_o, 1);
        check("res_gcd", res_gcd_o, exp_gcd);
        check("res_status", int'(res_status_o), exp_status);
        check("res_coprime", res_coprime_o,
              (exp_status == int'(ST_OK)) && (exp_gcd == 1));
        for (int i = 0; i < res_wait; i++) begin
            tick();
            check("res_valid_hold", res_valid_o, 1);
            check("res_gcd_hold", res_gcd_o, exp_gcd);
            check("res_status_hold", int'(res_status_o), exp_status);
            check("cmd_ready_hold", cmd_ready_o, 0);
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("res_valid_done", res_valid_o, 0);
        check("cmd_ready_done", cmd_ready_o, 1);
        check("busy_done", busy_o, 0);
        check("req_count", n_req - req_before, zero ? 0 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, g;
        nreset_i    = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_a_i     = '0;
        cmd_b_i     = '0;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_gcd_i   = '0;
        res_ready_i = 1'b0;
        repeat (2) tick();
        check_reset_values("rst");
        nreset_i = 1'b1;
        tick();

        // Directed cases
        run_txn(12, 18, 0, 3, 0);
        run_txn(7, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0);
        run_txn(9, 4, 0, 1, 5);
        run_txn(20, 30, 0, 100, 1);

        // Late response in S_IDLE is ignored.
        rsp_valid_i = 1'b1;
        rsp_gcd_i   = 8'd10;
        tick();
        rsp_valid_i = 1'b0;
        check("late_rsp_res_valid", res_valid_o, 0);
        check("late_rsp_cmd_ready", cmd_ready_o, 1);

        run_txn(15, 25, 3, 2, 0);
        run_txn(36, 24, 1, TB_TIMEOUT, 0);
        run_txn(50, 50, 0, 0, 0);

        // Reset in the middle of S_WAIT.
        cmd_valid_i = 1'b1;
        cmd_a_i = 8'd21;
        cmd_b_i = 8'd14;
        tick();
        cmd_valid_i = 1'b0;
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        tick();
        check("mid_wait_busy", busy_o, 1);
        nreset_i = 1'b0;
        #1;
        check_reset_values("mid_rst");
        tick();
        nreset_i = 1'b1;
        rsp_valid_i = 1'b1;
        rsp_gcd_i = 8'd7;
        tick();
        rsp_valid_i = 1'b0;
        check("post_rst_res_valid", res_valid_o, 0);
        check("post_rst_cmd_ready", cmd_ready_o, 1);
        run_txn(21, 14, 0, 2, 0);

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            g = $urandom_range(1, 15);
            a = ($urandom_range(0, 7) == 0) ? 0 : g * $urandom_range(1, 17);
            b = ($urandom_range(0, 7) == 0) ? 0 : g * $urandom_range(1, 17);
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 255);
            run_txn(a, b, $urandom_range(0, 3), $urandom_range(0, 6),
                    $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gcd_requester
